// File: rtl/csc_rgb_packer_if.sv
// Pixel stream handshake between the upsampler (master) and the colour-space
// converter / RGB packer (slave).
interface csc_rgb_packer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_y;
  logic [7:0] in_u;
  logic [7:0] in_v;

  modport master (output in_valid, output in_y, output in_u, output in_v, input in_ready);
  modport slave  (input in_valid, input in_y, input in_u, input in_v, output in_ready);
endinterface

// File: rtl/csc_rgb_packer.sv
// YUV -> RGB conversion with clipping, packing pixel pairs into three 16-bit SRAM words.
// Optional CSC_CLIP_COUNT_EN adds a saturating count of pixels with any clipped channel.
module csc_rgb_packer #(
  parameter int unsigned       NUM_PIXELS = 76800,
  parameter int unsigned       ADDR_W     = 18,
  parameter logic [ADDR_W-1:0] RGB_BASE   = 18'd146944
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              start,
  csc_rgb_packer_if.slave   pix,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              busy,
  output logic              done
`ifdef CSC_CLIP_COUNT_EN
  ,
  output logic [16:0]       clip_count
`endif
);

  localparam int unsigned NUM_WORDS = 3 * NUM_PIXELS / 2;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic              start_go, finish;
  logic [CNT_W-1:0]  acc_cnt_q, word_cnt_q;
  logic [1:0]        credits_q;
  logic              accept, push, pop, wr_en;

  // Stage 1: offset inputs and form the three fixed-point sums.
  logic signed [31:0] y_s, u_s, v_s;
  logic signed [31:0] r_q, g_q, b_q;
  logic               s1_valid_q;

  // Three-entry pixel buffer feeding the packer.
  logic [23:0] fifo_q [3];
  logic [1:0]  wr_ptr_q, rd_ptr_q, fifo_cnt_q;
  logic [23:0] rgb_s2, head;

  // Packer.
  logic [1:0]        phase_q;
  logic [7:0]        held_b_q, held_g_q;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr_q;

  function automatic logic [7:0] clip8(input logic signed [31:0] v);
    logic signed [31:0] s;
    s = v >>> 16;
    if (s < 0)        return 8'd0;
    else if (s > 255) return 8'hFF;
    else              return s[7:0];
  endfunction

  function automatic logic clipped(input logic signed [31:0] v);
    logic signed [31:0] s;
    s = v >>> 16;
    return (s < 0) || (s > 255);
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign pix.in_ready = (state_q == S_RUN) && (acc_cnt_q < CNT_W'(NUM_PIXELS)) && (credits_q != 2'd0);
  assign accept       = pix.in_valid && pix.in_ready;
  assign busy         = (state_q == S_RUN);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    finish   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_RUN;
        start_go = 1'b1;
      end
      S_RUN: if (accept && (acc_cnt_q == CNT_W'(NUM_PIXELS - 1))) state_d = S_FLUSH;
      S_FLUSH: if (word_cnt_q == CNT_W'(NUM_WORDS)) begin
        state_d = S_IDLE;
        finish  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      done       <= 1'b0;
      acc_cnt_q  <= '0;
      word_cnt_q <= '0;
      credits_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      done    <= finish;
      if (start_go)    acc_cnt_q <= '0;
      else if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
      if (start_go)    word_cnt_q <= '0;
      else if (wr_en)  word_cnt_q <= word_cnt_q + 1'b1;
      case ({accept, pop})
        2'b10:   credits_q <= credits_q - 2'd1;
        2'b01:   credits_q <= credits_q + 2'd1;
        default: credits_q <= credits_q;
      endcase
    end
  end

  always_comb begin
    y_s = $signed({24'd0, pix.in_y}) - 32'sd16;
    u_s = $signed({24'd0, pix.in_u}) - 32'sd128;
    v_s = $signed({24'd0, pix.in_v}) - 32'sd128;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      s1_valid_q <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        r_q <= 32'sd76284 * y_s + 32'sd104595 * v_s;
        g_q <= 32'sd76284 * y_s - 32'sd25624 * u_s - 32'sd53281 * v_s;
        b_q <= 32'sd76284 * y_s + 32'sd132251 * u_s;
      end
    end
  end

  // Stage 2: shift, clip and push straight into the buffer.
  assign rgb_s2 = {clip8(r_q), clip8(g_q), clip8(b_q)};
  assign push   = s1_valid_q;
  assign head   = fifo_q[rd_ptr_q];

  // NOTE: the buffer entries are reset along with the pointers so an aborted frame leaves nothing behind.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= rgb_s2;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Phase 2 only emits held bytes; phases 0 and 1 each consume one buffered pixel.
  assign wr_en = (state_q != S_IDLE) && ((phase_q == 2'd2) || (fifo_cnt_q != 2'd0));
  assign pop   = wr_en && (phase_q != 2'd2);

  always_comb begin
    wr_data = '0;
    case (phase_q)
      2'd0:    wr_data = {head[23:16], head[15:8]};
      2'd1:    wr_data = {held_b_q, head[23:16]};
      default: wr_data = {held_g_q, held_b_q};
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      phase_q         <= '0;
      held_b_q        <= '0;
      held_g_q        <= '0;
      wr_addr_q       <= RGB_BASE;
      SRAM_address    <= RGB_BASE;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
    end else begin
      SRAM_we_n <= !wr_en;
      if (start_go) begin
        wr_addr_q    <= RGB_BASE;
        SRAM_address <= RGB_BASE;
      end else if (wr_en) begin
        SRAM_write_data <= wr_data;
        SRAM_address    <= wr_addr_q;
        wr_addr_q       <= wr_addr_q + 1'b1;
        phase_q         <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        if (phase_q == 2'd0) held_b_q <= head[7:0];
        if (phase_q == 2'd1) begin
          held_g_q <= head[15:8];
          held_b_q <= head[7:0];
        end
      end
    end
  end

`ifdef CSC_CLIP_COUNT_EN
  logic any_clip;
  assign any_clip = clipped(r_q) || clipped(g_q) || clipped(b_q);

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn)                                        clip_count <= '0;
    else if (start_go)                                  clip_count <= '0;
    else if (push && any_clip && (clip_count != '1))    clip_count <= clip_count + 17'd1;
  end
`endif

endmodule

// File: tb/tb_csc_rgb_packer.sv
// Directed bench for csc_rgb_packer: a 2-pixel instance for grey/clipping vectors
// and an 8-pixel instance for back-pressure, stalls, mid-frame reset and repeated start.
module tb_csc_rgb_packer;
  localparam logic [17:0] BASE = 18'd146944;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, start_a, start_b;
  csc_rgb_packer_if pa ();
  csc_rgb_packer_if pb ();

  logic [17:0] addr_a, addr_b;
  logic [15:0] wd_a, wd_b;
  logic        we_a, we_b, busy_a, busy_b, done_a, done_b;
`ifdef CSC_CLIP_COUNT_EN
  logic [16:0] cc_a, cc_b;
`endif

  csc_rgb_packer #(.NUM_PIXELS(2)) dut_a (
    .Clock_50(clk), .Resetn(rst_n), .start(start_a), .pix(pa),
    .SRAM_address(addr_a), .SRAM_write_data(wd_a), .SRAM_we_n(we_a),
    .busy(busy_a), .done(done_a)
`ifdef CSC_CLIP_COUNT_EN
    , .clip_count(cc_a)
`endif
  );

  csc_rgb_packer #(.NUM_PIXELS(8)) dut_b (
    .Clock_50(clk), .Resetn(rst_n), .start(start_b), .pix(pb),
    .SRAM_address(addr_b), .SRAM_write_data(wd_b), .SRAM_we_n(we_b),
    .busy(busy_b), .done(done_b)
`ifdef CSC_CLIP_COUNT_EN
    , .clip_count(cc_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [33:0] wq_a[$];
  logic [33:0] wq_b[$];
  int done_cnt_a, done_cnt_b, done_cyc_a, done_cyc_b, last_wr_a, last_wr_b;
  int first_acc_a, first_wr_a, acc_b, pops_b, max_out_b;

  logic [7:0] px_y[16], px_u[16], px_v[16];

  // Write/accept monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!we_a) begin
      if (wq_a.size() == 0) first_wr_a = cyc;
      wq_a.push_back({addr_a, wd_a});
      last_wr_a = cyc;
    end
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (pa.in_valid && pa.in_ready && first_acc_a < 0) first_acc_a = cyc;
    if (!we_b) begin
      if (wq_b.size() % 3 != 2) pops_b++;
      wq_b.push_back({addr_b, wd_b});
      last_wr_b = cyc;
    end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    if (pb.in_valid && pb.in_ready) begin
      acc_b++;
      if (acc_b - pops_b > max_out_b) max_out_b = acc_b - pops_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat(input longint x);
    longint q;
    if (x < 0) return 8'd0;
    q = x / 65536;
    if (q > 255) return 8'hFF;
    return 8'(q);
  endfunction

  function automatic logic [23:0] ref_rgb(input int y, input int u, input int v);
    longint yp, up, vp;
    yp = longint'(y) - 16;
    up = longint'(u) - 128;
    vp = longint'(v) - 128;
    return {sat(76284 * yp + 104595 * vp),
            sat(76284 * yp - 25624 * up - 53281 * vp),
            sat(76284 * yp + 132251 * up)};
  endfunction

  task automatic set_in(input bit sel, input logic vld, input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    if (sel) begin
      pb.in_valid = vld; pb.in_y = y; pb.in_u = u; pb.in_v = v;
    end else begin
      pa.in_valid = vld; pa.in_y = y; pa.in_u = u; pa.in_v = v;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the pixel.
  task automatic drive(input bit sel, input logic [7:0] y, input logic [7:0] u, input logic [7:0] v, input int gap);
    for (int i = 0; i < gap; i++) begin
      set_in(sel, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
    end
    set_in(sel, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sel ? pb.in_ready : pa.in_ready) begin
        set_in(sel, 1'b1, y, u, v);
        @(posedge clk); #1;
        return;
      end
      set_in(sel, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    n_tests++;
    n_fail++;
    $error("FAIL drive_timeout: observed in_ready=0 for 200 cycles expected accept");
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        repeat (3) @(posedge clk);
        #1;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $error("FAIL %s_done_timeout: observed done=0 for 200 cycles expected pulse", tag);
    @(posedge clk); #1;
  endtask

  task automatic check_word_a(input string tag, input int k, input logic [15:0] exp);
    logic [33:0] e;
    if (k < wq_a.size()) begin
      e = wq_a[k];
      check({tag, "_addr"}, e[33:16], BASE + 18'(k));
      check({tag, "_data"}, e[15:0], exp);
    end
  endtask

  task automatic run_pair_a(input string tag, input logic [7:0] y0, input logic [7:0] u0, input logic [7:0] v0,
                            input logic [7:0] y1, input logic [7:0] u1, input logic [7:0] v1,
                            input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    wq_a.delete();
    done_cnt_a  = 0;
    first_acc_a = -1;
    pulse_start(0);
    check({tag, "_busy"}, busy_a, 1'b1);
    drive(0, y0, u0, v0, 0);
    drive(0, y1, u1, v1, 0);
    set_in(0, 1'b0, 8'd0, 8'd0, 8'd0);
    wait_done(0, tag);
    check({tag, "_wr_count"}, wq_a.size(), 3);
    check_word_a({tag, "_w0"}, 0, w0);
    check_word_a({tag, "_w1"}, 1, w1);
    check_word_a({tag, "_w2"}, 2, w2);
    check({tag, "_done_count"}, done_cnt_a, 1);
    check({tag, "_first_wr_latency"}, first_wr_a - first_acc_a, 3);
    check({tag, "_done_after_last"}, done_cyc_a - last_wr_a, 1);
    check({tag, "_busy_end"}, busy_a, 1'b0);
  endtask

  task automatic run_frame_b(input string tag, input int base, input bit stall, input bit hold, input int mid);
    logic [23:0] p0, p1;
    logic [15:0] w[3];
    logic [33:0] e;
    wq_b.delete();
    done_cnt_b = 0;
    acc_b      = 0;
    pops_b     = 0;
    max_out_b  = 0;
    pulse_start(1);
    for (int i = 0; i < 8; i++) begin
      if (i == mid) begin
        set_in(1, 1'b0, 8'd0, 8'd0, 8'd0);
        pulse_start(1);
      end
      drive(1, px_y[base+i], px_u[base+i], px_v[base+i], stall ? int'($urandom_range(0, 3)) : 0);
    end
    check({tag, "_ready_after_last"}, pb.in_ready, 1'b0);
    set_in(1, 1'b0, 8'd0, 8'd0, 8'd0);
    wait_done(1, tag);
    check({tag, "_wr_count"}, wq_b.size(), 12);
    for (int j = 0; j < 4; j++) begin
      p0 = ref_rgb(px_y[base+2*j], px_u[base+2*j], px_v[base+2*j]);
      p1 = ref_rgb(px_y[base+2*j+1], px_u[base+2*j+1], px_v[base+2*j+1]);
      w[0] = {p0[23:16], p0[15:8]};
      w[1] = {p0[7:0], p1[23:16]};
      w[2] = {p1[15:8], p1[7:0]};
      for (int k = 0; k < 3; k++) begin
        if (3*j + k < wq_b.size()) begin
          e = wq_b[3*j+k];
          check($sformatf("%s_w%0d_addr", tag, 3*j+k), e[33:16], BASE + 18'(3*j+k));
          check($sformatf("%s_w%0d_data", tag, 3*j+k), e[15:0], w[k]);
        end
      end
    end
    check({tag, "_done_count"}, done_cnt_b, 1);
    check({tag, "_done_after_last"}, done_cyc_b - last_wr_b, 1);
    if (hold) check({tag, "_max_outstanding"}, max_out_b, 3);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    set_in(0, 1'b0, 8'd0, 8'd0, 8'd0);
    set_in(1, 1'b0, 8'd0, 8'd0, 8'd0);
    done_cnt_a = 0; done_cnt_b = 0; first_acc_a = -1; first_wr_a = 0;
    acc_b = 0; pops_b = 0; max_out_b = 0;
    done_cyc_a = 0; done_cyc_b = 0; last_wr_a = 0; last_wr_b = 0;
    for (int i = 0; i < 16; i++) begin
      px_y[i] = 8'($urandom_range(0, 255));
      px_u[i] = 8'($urandom_range(0, 255));
      px_v[i] = 8'($urandom_range(0, 255));
    end
    px_y[0] = 8'd255; px_u[0] = 8'd128; px_v[0] = 8'd255;
    px_y[1] = 8'd0;   px_u[1] = 8'd128; px_v[1] = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_addr_b", addr_b, BASE);
    check("rst_data_b", wd_b, 16'h0000);
    check("rst_we_n_b", we_b, 1'b1);
    check("rst_ready_b", pb.in_ready, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_done_b", done_b, 1'b0);
    check("rst_addr_a", addr_a, BASE);
    check("rst_we_n_a", we_a, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready_a", pa.in_ready, 1'b0);

    // Grey pair and clipping on the 2-pixel instance
    run_pair_a("grey", 8'd16, 8'd128, 8'd128, 8'd235, 8'd128, 8'd128, 16'h0000, 16'h00FE, 16'hFEFE);
`ifdef CSC_CLIP_COUNT_EN
    check("grey_clip_count", cc_a, 17'd0);
`endif
    run_pair_a("clip", 8'd255, 8'd128, 8'd255, 8'd0, 8'd128, 8'd0, 16'hFFAE, 16'hFF00, 16'h5500);
`ifdef CSC_CLIP_COUNT_EN
    check("clip_clip_count", cc_a, 17'd2);
`endif

    // Back-pressure: in_valid held high for the whole frame
    run_frame_b("bp", 0, 1'b0, 1'b1, -1);

    // Source stalls over 16 pixels (two frames)
    run_frame_b("stall0", 0, 1'b1, 1'b0, -1);
    run_frame_b("stall1", 8, 1'b1, 1'b0, -1);

    // Reset mid-frame after 5 accepts
    pulse_start(1);
    for (int i = 0; i < 5; i++) drive(1, px_y[i], px_u[i], px_v[i], 0);
    set_in(1, 1'b0, 8'd0, 8'd0, 8'd0);
    #5;
    rst_n = 1'b0;
    #1;
    check("abort_addr", addr_b, BASE);
    check("abort_data", wd_b, 16'h0000);
    check("abort_we_n", we_b, 1'b1);
    check("abort_ready", pb.in_ready, 1'b0);
    check("abort_busy", busy_b, 1'b0);
    check("abort_done", done_b, 1'b0);
    wq_b.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_write", wq_b.size(), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_ready", pb.in_ready, 1'b0);
    check("abort_idle_writes", wq_b.size(), 0);
    run_frame_b("after_abort", 8, 1'b0, 1'b0, -1);

    // Second start during RUN is ignored
    run_frame_b("restart", 0, 1'b0, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
